mul_seq: RTL and testbench

- Iterative shift-add multiplier for the RISC-V M extension (MUL, MULH, MULHSU, MULHU).
- Sits beside the sequential divider in the execute stage.
- Uses the same level-held valid/ready request protocol as the divider, so the EX controller drives both units identically.
- Computes one partial product per clock on operand magnitudes, then applies the sign correction once at completion.

---
 rtl/mul_seq.sv | 133 +++++++++++++
 tb/tb_mul_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq
// Brief    : Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Revision : 1.0
// ============================================================================
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    input  logic                 valid,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result
);

    localparam int                CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WIDTH);
    localparam logic [1:0]        C_OP_MUL   = 2'b00;
    localparam logic [1:0]        C_OP_MULH  = 2'b01;
    localparam logic [1:0]        C_OP_MULSU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod_fin;

    always_comb begin
        w_a_neg    = a[WIDTH-1] & ((op == C_OP_MULH) || (op == C_OP_MULSU));
        w_b_neg    = b[WIDTH-1] & (op == C_OP_MULH);
        // The most-negative operand negates to itself, which is the correct unsigned magnitude.
        w_a_mag    = w_a_neg ? -a : a;
        w_b_mag    = w_b_neg ? -b : b;
        w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        w_step     = acc_q[0] ? {w_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        w_prod_fin = neg_q ? -acc_q : acc_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        ready_d   = ready_q;
        product_d = product_q;
        result_d  = result_q;

        if (!valid) begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    op_d    = op;
                    mcand_d = w_a_mag;
                    acc_d   = {{WIDTH{1'b0}}, w_b_mag};
                    neg_d   = w_a_neg ^ w_b_neg;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_q == C_CNT_LAST) begin
                        product_d = w_prod_fin;
                        result_d  = (op_q == C_OP_MUL) ? w_prod_fin[WIDTH-1:0]
                                                       : w_prod_fin[2*WIDTH-1:WIDTH];
                        ready_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        acc_d = w_step;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Hold until valid drops; a fresh request needs a trip through IDLE.
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            ready_q   <= 1'b0;
            product_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            ready_q   <= ready_d;
            product_q <= product_d;
            result_q  <= result_d;
        end
    end

    assign ready   = ready_q;
    assign product = product_q;
    assign result  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq
// Brief    : Self-checking bench for mul_seq against an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_mul_seq;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   a, b;
    logic [1:0]         op;
    logic               valid;
    logic               ready;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   result;

    int n_total = 0;
    int n_bad   = 0;

    mul_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .op      (op),
        .valid   (valid),
        .ready   (ready),
        .product (product),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: extend each operand per op, multiply at 64 bits.
    function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey;
        ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [63:0] p);
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Raise valid with the given operands, wait for ready, check latency and values.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit scramble, input string tag);
        logic [63:0] exp_p;
        int cyc;
        exp_p = ref_prod(o, x, y);
        op = o; a = x; b = y; valid = 1'b1;
        cyc = 0;
        while (!ready && cyc < 100) begin
            tick();
            cyc++;
            if (scramble && cyc == 5) begin
                a  = $urandom;
                b  = $urandom;
                op = 2'($urandom_range(0, 3));
            end
        end
        check({tag, "_lat"}, 64'(cyc - 1), 64'(WIDTH + 1));
        check({tag, "_prod"}, product, exp_p);
        check({tag, "_res"}, 64'(result), 64'(ref_res(o, exp_p)));
    endtask

    task automatic drop_valid();
        valid = 1'b0;
        tick();
    endtask

    logic [31:0] edge_vals [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    initial begin
        rst = 1'b1; valid = 1'b0; a = '0; b = '0; op = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_prod", product, 64'd0);
        check("rst_res", 64'(result), 64'd0);

        // Basic MUL with hold
        do_op(2'b00, 32'd7, 32'd6, 1'b0, "mul7x6");
        check("mul7x6_val", product, 64'h2A);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_ready", 64'(ready), 64'd1);
            check("hold_prod", product, 64'h2A);
        end
        drop_valid();
        check("drop_ready", 64'(ready), 64'd0);
        check("drop_hold_prod", product, 64'h2A);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulh_m1");
        check("mulh_m1_val", product, 64'h1);
        drop_valid();
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
        check("mulh_min_val", product, 64'h4000_0000_0000_0000);
        drop_valid();
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu");
        check("mulhsu_val", product, 64'hFFFF_FFFF_0000_0001);
        drop_valid();
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu");
        check("mulhu_val", product, 64'hFFFF_FFFE_0000_0001);
        drop_valid();

        // Abort mid-run: ready must never rise, last product stays visible
        begin
            bit saw_ready;
            saw_ready = 1'b0;
            op = 2'b11; a = 32'd3; b = 32'd5; valid = 1'b1;
            for (int i = 0; i < 11; i++) begin
                tick();
                if (ready) saw_ready = 1'b1;
            end
            valid = 1'b0;
            tick();
            if (ready) saw_ready = 1'b1;
            check("abort_ready", 64'(saw_ready), 64'd0);
            check("abort_prod_hold", product, 64'hFFFF_FFFE_0000_0001);
        end
        do_op(2'b11, 32'd3, 32'd5, 1'b0, "after_abort");
        check("after_abort_val", product, 64'd15);
        drop_valid();

        // Input changes mid-run
        do_op(2'b01, 32'hFFFF_FFF9, 32'd6, 1'b1, "scramble");
        drop_valid();

        // Reset mid-run
        op = 2'b00; a = 32'd9; b = 32'd9; valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_prod", product, 64'd0);
        rst = 1'b0; valid = 1'b0;
        tick();

        // Back-to-back: no restart while valid stays high
        do_op(2'b00, 32'd2, 32'd3, 1'b0, "b2b_first");
        begin
            bit bad;
            bad = 1'b0;
            a = 32'd4; b = 32'd5;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (!ready || product != 64'd6) bad = 1'b1;
            end
            check("b2b_no_restart", 64'(bad), 64'd0);
        end
        drop_valid();
        do_op(2'b00, 32'd4, 32'd5, 1'b0, "b2b_second");
        check("b2b_second_val", product, 64'd20);
        drop_valid();

        // Randomized operands, with edge values mixed in
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = (i % 3 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            y = (i % 4 == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            do_op(2'($urandom_range(0, 3)), x, y, (i % 2 == 1), "rand");
            drop_valid();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
